// File: rtl/spi_xfer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_seq_pkg
//  Description : Shared types and constants for the SPI transfer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_xfer_seq_pkg;

    // Sequencer states: flush the FIFOs, run the framed transfer, hold CS off.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_RUN    = 2'd2,
        ST_CSHOLD = 2'd3
    } state_t;

    // Largest header the 32-bit header word can carry.
    localparam logic [2:0] HDR_MAX = 3'd4;

    // Header lengths above HDR_MAX are treated as HDR_MAX.
    function automatic logic [2:0] clamp_hdr_len(input logic [2:0] l);
        return (l > HDR_MAX) ? HDR_MAX : l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_seq
//  Description : Runs one chip-select-framed SPI transfer (header + data
//                phase) by driving the controller's TX/RX FIFOs, streaming
//                write data in and read data out over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_seq
    import spi_xfer_seq_pkg::*;
#(
    parameter int unsigned LW   = 8,
    parameter int unsigned RXD  = 15,
    parameter logic [7:0]  FILL = 8'hFF,
    parameter int unsigned CSH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          dir,
    input  logic [2:0]    hdr_len,
    input  logic [31:0]   hdr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    input  logic [7:0]    s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [7:0]    m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          spi_wr,
    output logic [7:0]    spi_datai,
    input  logic          spi_tx_full,
    output logic          spi_rd,
    input  logic [7:0]    spi_datao,
    input  logic          spi_rx_empty,
    output logic          spi_rx_en,
    output logic          spi_tx_flush,
    output logic          spi_rx_flush,
    output logic          spi_ss
);

    // Counters span header + data, so one bit wider than the length field.
    localparam int unsigned    CW       = LW + 1;
    localparam int unsigned    CSW      = (CSH > 1) ? $clog2(CSH) : 1;
    localparam logic [CSW-1:0] CSH_LAST = CSW'(CSH - 1);
    localparam logic [CW-1:0]  RXD_LIM  = CW'(RXD);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_dir;
    logic [2:0]      r_hdr_len;
    logic [CW-1:0]   r_total;
    logic [CW-1:0]   r_tx_cnt;
    logic [CW-1:0]   r_rx_cnt;
    logic [31:0]     r_hdr_sr;
    logic [CSW-1:0]  r_csh_cnt;

    logic [2:0]      w_hl_in;
    logic [5:0]      w_hdr_shamt;
    logic [CW-1:0]   w_hl_ext;
    logic [CW-1:0]   w_inflight;
    logic            w_run;
    logic            w_tx_hdr;
    logic            w_tx_room;
    logic            w_rx_fwd;
    logic            w_rx_avail;
    logic            w_last_pop;

    assign w_hl_in     = clamp_hdr_len(hdr_len);
    assign w_hdr_shamt = {HDR_MAX - w_hl_in, 3'b000};
    assign w_hl_ext    = CW'(r_hdr_len);
    assign w_inflight  = r_tx_cnt - r_rx_cnt;
    assign w_run       = (r_state == ST_RUN);
    assign w_tx_hdr    = (r_tx_cnt < w_hl_ext);
    // Throttling on bytes in flight keeps the RX FIFO from overflowing
    // while the read stream is back-pressured.
    assign w_tx_room   = w_run && (r_tx_cnt < r_total) && !spi_tx_full
                         && (w_inflight < RXD_LIM);
    assign w_rx_fwd    = r_dir && !(r_rx_cnt < w_hl_ext);
    assign w_rx_avail  = w_run && !spi_rx_empty && (r_rx_cnt < r_total);
    assign w_last_pop  = spi_rd && ((r_rx_cnt + CW'(1)) == r_total);

    // State register plus the registered control outputs, derived from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            spi_ss       <= 1'b0;
            spi_rx_en    <= 1'b0;
            spi_tx_flush <= 1'b0;
            spi_rx_flush <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            busy         <= (w_state_nxt != ST_IDLE);
            done         <= (r_state == ST_CSHOLD) && (w_state_nxt == ST_IDLE);
            spi_ss       <= (w_state_nxt == ST_RUN);
            spi_rx_en    <= (w_state_nxt == ST_RUN);
            spi_tx_flush <= (w_state_nxt == ST_FLUSH);
            spi_rx_flush <= (w_state_nxt == ST_FLUSH);
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_FLUSH;
            ST_FLUSH:  w_state_nxt = (r_total == '0) ? ST_CSHOLD : ST_RUN;
            ST_RUN:    if (w_last_pop) w_state_nxt = ST_CSHOLD;
            ST_CSHOLD: if (r_csh_cnt == CSH_LAST) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Streaming handshakes and FIFO strobes for the TX and RX sides.
    always_comb begin
        spi_wr    = w_tx_room && (w_tx_hdr || r_dir || s_tvalid);
        s_tready  = w_tx_room && !w_tx_hdr && !r_dir && s_tvalid;
        spi_datai = 8'h00;
        if (spi_wr) begin
            if (w_tx_hdr)   spi_datai = r_hdr_sr[31:24];
            else if (r_dir) spi_datai = FILL;
            else            spi_datai = s_tdata;
        end
        m_tvalid = w_rx_avail && w_rx_fwd;
        m_tdata  = m_tvalid ? spi_datao : 8'h00;
        spi_rd   = w_rx_avail && (!w_rx_fwd || m_tready);
    end

    // Command latch, byte counters, header shifter and CS-hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir     <= 1'b0;
            r_hdr_len <= 3'd0;
            r_total   <= '0;
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_hdr_sr  <= 32'h0;
            r_csh_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_dir     <= dir;
                    r_hdr_len <= w_hl_in;
                    r_total   <= CW'(w_hl_in) + CW'(len);
                    r_hdr_sr  <= hdr << w_hdr_shamt;
                    r_tx_cnt  <= '0;
                    r_rx_cnt  <= '0;
                end
            end else if (w_run) begin
                if (spi_wr) begin
                    r_tx_cnt <= r_tx_cnt + CW'(1);
                    if (w_tx_hdr) r_hdr_sr <= {r_hdr_sr[23:0], 8'h00};
                end
                if (spi_rd) r_rx_cnt <= r_rx_cnt + CW'(1);
            end
            r_csh_cnt <= (r_state == ST_CSHOLD) ? r_csh_cnt + CSW'(1) : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_xfer_seq
//  Description : Self-checking bench for spi_xfer_seq with a behavioural SPI
//                controller (TX/RX FIFOs plus a byte-shifting engine).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_seq;

    localparam int         LW      = 8;
    localparam int         RXD     = 15;
    localparam int         CSH     = 2;
    localparam logic [7:0] FILL    = 8'hFF;
    localparam int         TXDEPTH = 4;
    localparam int         RXDEPTH = 16;
    localparam int         ENG     = 2;

    logic          clk, rst_n, start, dir;
    logic [2:0]    hdr_len;
    logic [31:0]   hdr;
    logic [LW-1:0] len;
    logic          busy, done;
    logic [7:0]    s_tdata;
    logic          s_tvalid, s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready;
    logic          spi_wr, spi_tx_full, spi_rd, spi_rx_empty;
    logic [7:0]    spi_datai, spi_datao;
    logic          spi_rx_en, spi_tx_flush, spi_rx_flush, spi_ss;

    spi_xfer_seq #(.LW(LW), .RXD(RXD), .FILL(FILL), .CSH(CSH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
        .hdr_len(hdr_len), .hdr(hdr), .len(len), .busy(busy), .done(done),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .spi_wr(spi_wr), .spi_datai(spi_datai), .spi_tx_full(spi_tx_full),
        .spi_rd(spi_rd), .spi_datao(spi_datao), .spi_rx_empty(spi_rx_empty),
        .spi_rx_en(spi_rx_en), .spi_tx_flush(spi_tx_flush),
        .spi_rx_flush(spi_rx_flush), .spi_ss(spi_ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Controller model state
    logic [7:0] txq[$], rxq[$], resp_q[$];
    logic [7:0] tx_log[$], rx_log[$], m_log[$];
    int eng_cnt = 0;
    int tx_ovf = 0, rx_ovf = 0;

    // Stream source / sink control
    logic [7:0] src [0:255];
    int src_n = 0, src_idx = 0;
    bit gap = 0;
    int mrdy_mode = 0, mrdy_hold = 0;

    // Monitor samples and per-transfer statistics
    int cyc = 0;
    logic smp_wr = 0, smp_rd = 0, smp_txf = 0, smp_rxf = 0, smp_shs = 0;
    logic [7:0] smp_wd = 0;
    logic prev_ss = 0;
    int wr_cnt, rd_cnt, shs_cnt, mvalid_cnt, max_inflight;
    int ss_rises, ss_falls, ss_fall_cyc, last_rd_cyc;
    int flush_cnt, flush_cyc, done_cnt, done_cyc, done_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample DUT outputs mid-cycle, where everything has settled.
    always @(negedge clk) begin
        cyc++;
        smp_wr  = spi_wr;
        smp_wd  = spi_datai;
        smp_rd  = spi_rd;
        smp_txf = spi_tx_flush;
        smp_rxf = spi_rx_flush;
        smp_shs = s_tvalid && s_tready;
        if (spi_wr) begin tx_log.push_back(spi_datai); wr_cnt++; end
        if (spi_rd) begin rd_cnt++; last_rd_cyc = cyc; end
        if (m_tvalid) mvalid_cnt++;
        if (m_tvalid && m_tready) m_log.push_back(m_tdata);
        if (smp_shs) shs_cnt++;
        if (wr_cnt - rd_cnt > max_inflight) max_inflight = wr_cnt - rd_cnt;
        if (spi_ss && !prev_ss) ss_rises++;
        if (!spi_ss && prev_ss) begin ss_falls++; ss_fall_cyc = cyc; end
        prev_ss = spi_ss;
        if (spi_tx_flush) begin flush_cnt++; flush_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; if (busy) done_busy++; end
    end

    // Apply the FIFO operations seen at the edge, run the engine, drive streams.
    always begin
        logic [7:0] resp;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            eng_cnt = 0;
        end else begin
            if (smp_rd && rxq.size() > 0) void'(rxq.pop_front());
            if (smp_wr) begin
                if (txq.size() >= TXDEPTH) tx_ovf++;
                txq.push_back(smp_wd);
            end
            if (smp_txf) txq.delete();
            if (smp_rxf) begin rxq.delete(); rx_log.delete(); eng_cnt = 0; end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && spi_rx_en) begin
                    resp = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
                    if (rxq.size() >= RXDEPTH) rx_ovf++;
                    else rxq.push_back(resp);
                    rx_log.push_back(resp);
                end
            end else if (txq.size() > 0) begin
                void'(txq.pop_front());
                eng_cnt = ENG;
            end
            if (smp_shs) src_idx++;
        end
        spi_tx_full  = (txq.size() >= TXDEPTH);
        spi_rx_empty = (rxq.size() == 0);
        spi_datao    = spi_rx_empty ? 8'h00 : rxq[0];
        s_tvalid     = (src_idx < src_n) && (!gap || (cyc % 3 == 0));
        s_tdata      = (src_idx < src_n) ? src[src_idx] : 8'h00;
        case (mrdy_mode)
            0: m_tready = 1'b1;
            1: begin m_tready = (mrdy_hold == 0); if (mrdy_hold > 0) mrdy_hold--; end
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic clear_stats();
        tx_log.delete(); m_log.delete();
        wr_cnt = 0; rd_cnt = 0; shs_cnt = 0; mvalid_cnt = 0; max_inflight = 0;
        ss_rises = 0; ss_falls = 0; ss_fall_cyc = -1; last_rd_cyc = -1;
        flush_cnt = 0; flush_cyc = -1; done_cnt = 0; done_cyc = -1; done_busy = 0;
        tx_ovf = 0; rx_ovf = 0;
    endtask

    task automatic pulse_start(input logic d, input logic [2:0] hl, input logic [31:0] h, input int n);
        @(posedge clk); #2;
        start = 1'b1; dir = d; hdr_len = hl; hdr = h; len = LW'(n);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // One complete transfer; expectations are derived from the command alone.
    task automatic run_xfer(input string tag, input logic d, input logic [2:0] hl,
                            input logic [31:0] h, input int n, input int limit, input bit dbl);
        int hle, got;
        logic [7:0] e;
        hle = (hl > 3'd4) ? 4 : int'(hl);
        src_idx = 0;
        src_n   = d ? 0 : n;
        clear_stats();
        pulse_start(d, hl, h, n);
        if (dbl) pulse_start(~d, 3'd4, 32'hDEADBEEF, 7);
        got = 0;
        for (int k = 0; k < limit && got == 0; k++) begin
            @(posedge clk); #3;
            if (done_cnt > 0) got = 1;
        end
        check({tag, ":done_seen"}, 32'(got), 32'd1);
        repeat (6) @(posedge clk);
        #3;
        check({tag, ":tx_bytes"}, 32'(tx_log.size()), 32'(hle + n));
        for (int i = 0; i < tx_log.size() && i < hle + n; i++) begin
            if (i < hle) e = h[8*(hle-1-i) +: 8];
            else         e = d ? FILL : src[i-hle];
            check($sformatf("%s:tx[%0d]", tag, i), 32'(tx_log[i]), 32'(e));
        end
        check({tag, ":pops"}, 32'(rd_cnt), 32'(hle + n));
        if (d) begin
            check({tag, ":m_beats"}, 32'(m_log.size()), 32'(n));
            for (int j = 0; j < m_log.size() && j < n; j++)
                if (hle + j < rx_log.size())
                    check($sformatf("%s:m[%0d]", tag, j), 32'(m_log[j]), 32'(rx_log[hle+j]));
        end else begin
            check({tag, ":no_mvalid"}, 32'(mvalid_cnt), 32'd0);
            check({tag, ":s_hs"}, 32'(shs_cnt), 32'(n));
        end
        check({tag, ":done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, ":busy_at_done"}, 32'(done_busy), 32'd0);
        check({tag, ":flush_cnt"}, 32'(flush_cnt), 32'd1);
        check({tag, ":ovf"}, 32'(tx_ovf + rx_ovf), 32'd0);
        check({tag, ":inflight_ok"}, 32'(max_inflight <= RXD), 32'd1);
        if (hle + n > 0) begin
            check({tag, ":ss_rises"}, 32'(ss_rises), 32'd1);
            check({tag, ":ss_falls"}, 32'(ss_falls), 32'd1);
            check({tag, ":ss_fall"}, 32'(ss_fall_cyc), 32'(last_rd_cyc + 1));
            check({tag, ":done_lat"}, 32'(done_cyc), 32'(ss_fall_cyc + CSH));
        end else begin
            check({tag, ":ss_rises"}, 32'(ss_rises), 32'd0);
            check({tag, ":done_lat"}, 32'(done_cyc), 32'(flush_cyc + CSH + 1));
        end
        if (got == 0) begin
            rst_n = 1'b0; #20; rst_n = 1'b1;
        end
    endtask

    initial begin
        logic       rd;
        logic [2:0] hl;
        int         n;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; hdr_len = 3'd0; hdr = 32'h0; len = '0;
        s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
        spi_tx_full = 1'b0; spi_rx_empty = 1'b1; spi_datao = 8'h00;
        repeat (3) @(posedge clk);
        #3;
        check("reset_outs",
              32'({busy, done, s_tready, m_tvalid, m_tdata, spi_wr, spi_datai, spi_rd,
                   spi_rx_en, spi_tx_flush, spi_rx_flush, spi_ss}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write with one header byte
        src[0] = 8'hA1; src[1] = 8'hA2; src[2] = 8'hA3;
        run_xfer("wr_basic", 1'b0, 3'd1, 32'h0000_0002, 3, 400, 1'b0);

        // Read with a full header and known response bytes
        resp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3};
        run_xfer("rd_hdr4", 1'b1, 3'd4, 32'h0B12_3456, 2, 400, 1'b0);
        check("rd_hdr4:first", 32'(m_log.size() > 0 ? m_log[0] : 8'h00), 32'h5A);
        check("rd_hdr4:second", 32'(m_log.size() > 1 ? m_log[1] : 8'h00), 32'hC3);

        // Long read with the sink stalled for 100 cycles
        mrdy_mode = 1; mrdy_hold = 100;
        run_xfer("rd_stall", 1'b1, 3'd0, 32'h0, 40, 3000, 1'b0);
        check("rd_stall:inflight_peak", 32'(max_inflight), 32'(RXD));
        mrdy_mode = 0;

        // Empty transfer, with a second start while busy
        run_xfer("empty", 1'b0, 3'd0, 32'h0, 0, 100, 1'b1);

        // Gapped write source
        gap = 1;
        for (int i = 0; i < 5; i++) src[i] = 8'($urandom);
        run_xfer("wr_gap", 1'b0, 3'd0, 32'h0, 5, 600, 1'b0);
        gap = 0;

        // Reset in the middle of a read
        clear_stats();
        src_n = 0;
        pulse_start(1'b1, 3'd2, 32'h0000_9911, 20);
        repeat (8) @(posedge clk);
        #3;
        check("mid_ss_before", 32'(spi_ss), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_drop", 32'({spi_ss, busy, spi_wr, spi_rd}), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
        run_xfer("post_rst", 1'b0, 3'd2, 32'h0000_C0DE, 4, 400, 1'b0);

        // Randomised transfers with a random sink
        mrdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            rd = 1'($urandom_range(0, 1));
            hl = 3'($urandom_range(0, 7));
            n  = $urandom_range(0, 24);
            gap = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) src[i] = 8'($urandom);
            run_xfer($sformatf("rand%0d", t), rd, hl, $urandom, n, 2000, 1'b0);
        end
        gap = 0;
        mrdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
